// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the iterative restoring divider.
//   DIV_WIDTH   default operand/quotient/remainder width
//   DIV_CNT_W   width of the iteration counter for the default width
//   div_state_t FSM encoding: IDLE, BUSY (one quotient bit per cycle), DONE
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division iteration.
//   partial   in   WIDTH  shifted remainder with the next dividend bit appended
//   divisor   in   WIDTH  divisor (magnitude)
//   next_rem  out  WIDTH  remainder after this step (difference or restored partial)
//   q_bit     out  1      quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] w_diff;

    // partial - divisor as an adder with inverted operand and carry-in of 1.
    // The extra top bit is the carry-out: 1 means the subtract did not borrow.
    assign w_diff   = {1'b0, partial} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    assign q_bit    = w_diff[WIDTH];
    assign next_rem = w_diff[WIDTH] ? w_diff[WIDTH-1:0] : partial;

endmodule

// File: rtl/divider.sv
// divider -- iterative restoring divider, one quotient bit per cycle.
//   Start with a one-cycle div_begin pulse in IDLE; results appear with the
//   div_end pulse WIDTH+1 cycles later and hold until the next accepted start.
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   div_begin   in   1      start pulse, only honoured in IDLE
//   div_signed  in   1      signed divide request (only with SIGNED_DIV_EN)
//   dividend    in   WIDTH  captured on an accepted start
//   divisor     in   WIDTH  captured on an accepted start
//   quotient    out  WIDTH  held result
//   remainder   out  WIDTH  held result
//   div_busy    out  1      iterating
//   div_end     out  1      one-cycle done pulse
// Configuration macro: SIGNED_DIV_EN -- adds magnitude conversion on start and
//   sign fix-up on the edge entering DONE. Without it every divide is unsigned.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_busy,
    output logic             div_end
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;        // dividend bits consumed MSB-first; quotient shifts in at LSB
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_next_rem;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;
    logic [WIDTH-1:0] w_dvd_in;
    logic [WIDTH-1:0] w_dsr_in;
    logic [WIDTH-1:0] w_q_out;
    logic [WIDTH-1:0] w_r_out;

    assign w_accept = (r_state == DIV_IDLE) && div_begin;
    assign w_last   = (r_state == DIV_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));

    // The remainder never exceeds the consumed dividend prefix, so its MSB is
    // always clear before the shift and dropping it loses nothing.
    assign w_partial = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial  (w_partial),
        .divisor  (r_dsr),
        .next_rem (w_next_rem),
        .q_bit    (w_q_bit)
    );

    // Results as they stand after the final iteration.
    assign w_q_final = {r_dvd[WIDTH-2:0], w_q_bit};
    assign w_r_final = w_next_rem;

`ifdef SIGNED_DIV_EN
    logic w_neg_dvd;
    logic w_neg_dsr;
    logic r_neg_q;
    logic r_neg_r;
    logic r_dsr_zero;

    assign w_neg_dvd = div_signed & dividend[WIDTH-1];
    assign w_neg_dsr = div_signed & divisor[WIDTH-1];
    assign w_dvd_in  = w_neg_dvd ? -dividend : dividend;
    assign w_dsr_in  = w_neg_dsr ? -divisor : divisor;

    // Divide by zero keeps the all-ones quotient regardless of signs; the
    // remainder path already restores the original dividend via r_neg_r.
    // The most-negative / -1 case falls out naturally: negating 2^(W-1) wraps to itself.
    assign w_q_out = r_dsr_zero ? {WIDTH{1'b1}} : (r_neg_q ? -w_q_final : w_q_final);
    assign w_r_out = r_neg_r ? -w_r_final : w_r_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dsr_zero <= 1'b0;
        end else if (w_accept) begin
            r_neg_q    <= w_neg_dvd ^ w_neg_dsr;
            r_neg_r    <= w_neg_dvd;
            r_dsr_zero <= (divisor == '0);
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = div_signed;
    assign w_dvd_in        = dividend;
    assign w_dsr_in        = divisor;
    assign w_q_out         = w_q_final;
    assign w_r_out         = w_r_final;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_next = r_state;
        div_busy     = 1'b0;
        div_end      = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (div_begin) begin
                    w_state_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                div_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                div_end      = 1'b1;
                w_state_next = DIV_IDLE;
            end
            default: begin
                w_state_next = DIV_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, result latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
                r_dvd <= w_dvd_in;
                r_dsr <= w_dsr_in;
                r_rem <= '0;
            end else if (r_state == DIV_BUSY) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                r_rem <= w_next_rem;
            end
            if (w_last) begin
                r_quotient  <= w_q_out;
                r_remainder <= w_r_out;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_divider.sv
// tb_divider -- directed and randomized checks of the divider against an
// arithmetic reference model (quotient/remainder computed with / and %).
module tb_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_begin = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_busy;
    logic        div_end;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    always #5 clk = ~clk;

    divider dut (
        .clk        (clk),
        .rst        (rst),
        .div_begin  (div_begin),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_busy   (div_busy),
        .div_end    (div_end)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model from the arithmetic definition of division.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end
`ifdef SIGNED_DIV_EN
        else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end
`endif
        else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // One divide. pulse_at: extra div_begin raised in the cycle with that
    // start-relative count (33 = the div_end cycle); 0 for none.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int pulse_at, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
        int          bcnt;
        model(a, b, s, eq, er);
        @(negedge clk);
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_begin  = 1'b1;
        @(posedge clk);
        #1;
        div_begin = 1'b0;
        lat  = 1;
        bcnt = div_busy ? 1 : 0;
        while (!div_end && lat < 100) begin
            if (lat == 5) begin
                chk({tag, "_hold_q"}, quotient, prev_q);
                chk({tag, "_hold_r"}, remainder, prev_r);
            end
            div_begin = (lat == pulse_at);
            if (div_begin) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
            if (div_busy) bcnt++;
        end
        div_begin = (lat == pulse_at);
        chk({tag, "_latency"}, 32'(lat), 32'd33);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd32);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        @(posedge clk);
        #1;
        div_begin = 1'b0;
        chk({tag, "_end_pulse"}, {31'd0, div_end}, 32'd0);
        chk({tag, "_idle_after"}, {31'd0, div_busy}, 32'd0);
        chk({tag, "_q_held"}, quotient, eq);
        $display("[TB] %s: %h / %h signed=%0d -> q=%h r=%h latency=%0d", tag, a, b, s,
                 quotient, remainder, lat);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #2;
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_busy", {31'd0, div_busy}, 32'd0);
        chk("rst_end", {31'd0, div_end}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, "u100_7");
        run_div(32'h1234, 32'd0, 1'b0, 0, "div0");
        run_div(32'd1000, 32'd33, 1'b0, 12, "repulse_busy");
        run_div(32'hDEAD_BEEF, 32'h0000_1357, 1'b0, 33, "repulse_end");

        // Reset asserted around iteration 10 aborts at once.
        @(negedge clk);
        dividend  = 32'd5000;
        divisor   = 32'd3;
        div_begin = 1'b1;
        @(posedge clk);
        #1;
        div_begin = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_busy", {31'd0, div_busy}, 32'd0);
        chk("midrst_end", {31'd0, div_end}, 32'd0);
        $display("[TB] mid-operation reset: q=%h r=%h busy=%0d", quotient, remainder, div_busy);
        @(negedge clk);
        rst    = 1'b0;
        prev_q = '0;
        prev_r = '0;
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "after_rst");

`ifdef SIGNED_DIV_EN
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
        run_div(32'hFFFF_FF00, 32'd0, 1'b1, 0, "s_div0");
        run_div(32'd77, 32'hFFFF_FFF6, 1'b1, 0, "s_77_m10");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0, "u_fff9_2");
`else
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "nosign_fff9_2");
`endif

        // Randomized operands, mixed signedness, occasional ignored re-pulse.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            if (i % 4 == 0) rb = $urandom_range(1, 15);
            else if (i == 7) rb = 32'd0;
            else if (i % 4 == 1) rb = $urandom >> $urandom_range(0, 31);
            else rb = $urandom;
            run_div(ra, rb, 1'($urandom_range(0, 1)),
                    (i % 3 == 0) ? int'($urandom_range(2, 33)) : 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
